// File: rtl/map_renderer.sv
// Map scanline renderer: per-line ROM row fetch into a line buffer, registered wall pixel out,
// plus an optional collision-query port sharing the ROM address (enable with MAP_QUERY_EN).
module map_renderer #(
    parameter int CELL_SHIFT = 3,
    parameter int FETCH_H    = 256,
    parameter int V_TOTAL    = 262
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  hpos,
    input  logic [8:0]  vpos,
    output logic [4:0]  map_row,
    input  logic [31:0] map_bits,
    output logic        wall_pixel,
    input  logic        query_valid,
    input  logic [4:0]  query_x,
    input  logic [4:0]  query_y,
    output logic        query_ready,
    output logic        hit_valid,
    output logic        hit
);
    localparam int MAP_PIX = 32 << CELL_SHIFT;

`ifdef MAP_QUERY_EN
    typedef enum logic [1:0] {IDLE, LFETCH, QFETCH, QRESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, LFETCH} state_t;
`endif

    state_t      state, state_next;
    logic [31:0] line_buf, next_buf;
    logic [4:0]  map_row_q;
    logic [8:0]  nl;
    logic [4:0]  nl_row, hcell;
    logic        fetch_trig, in_map;

    assign fetch_trig = (hpos == 9'(FETCH_H));
    assign nl         = (vpos == 9'(V_TOTAL - 1)) ? 9'd0 : vpos + 9'd1;
    assign nl_row     = 5'(nl >> CELL_SHIFT);
    assign hcell      = 5'(hpos >> CELL_SHIFT);
    assign in_map     = int'(hpos) < MAP_PIX;

`ifdef MAP_QUERY_EN
    logic       fetch_pend, pend_next, hit_r;
    logic [4:0] qry_x, qry_y;

    // Line fetches always win the ROM port, so a query is only taken on a fetch-free idle cycle.
    assign query_ready = reset_n && (state == IDLE) && !fetch_trig && !fetch_pend;
    assign hit_valid   = (state == QRESP);
    assign hit         = hit_r;
`else
    logic unused_query;

    assign unused_query = ^{query_valid, query_x, query_y};
    assign query_ready  = 1'b0;
    assign hit_valid    = 1'b0;
    assign hit          = 1'b0;
`endif

    always_comb begin
        state_next = state;
`ifdef MAP_QUERY_EN
        pend_next = fetch_pend;
`endif
        case (state)
            IDLE: begin
`ifdef MAP_QUERY_EN
                if (fetch_trig || fetch_pend) begin
                    state_next = LFETCH;
                    pend_next  = 1'b0;
                end else if (query_valid && query_ready) begin
                    state_next = QFETCH;
                end
`else
                if (fetch_trig) state_next = LFETCH;
`endif
            end
            default: begin
                state_next = IDLE;
`ifdef MAP_QUERY_EN
                if (state == QFETCH) state_next = QRESP;
                // A trigger seen while busy is remembered and served on the next idle cycle.
                if (fetch_trig) pend_next = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        map_row = map_row_q;
        if (state == LFETCH) map_row = nl_row;
`ifdef MAP_QUERY_EN
        else if (state == QFETCH) map_row = qry_y;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            line_buf   <= '0;
            next_buf   <= '0;
            map_row_q  <= '0;
            wall_pixel <= 1'b0;
        end else begin
            state     <= state_next;
            map_row_q <= map_row;
            // Lines past the bottom of the map render empty.
            if (state == LFETCH) next_buf <= (int'(nl) >= MAP_PIX) ? 32'd0 : map_bits;
            if (hpos == 9'd0) line_buf <= next_buf;
            wall_pixel <= in_map ? line_buf[5'd31 - hcell] : 1'b0;
        end
    end

`ifdef MAP_QUERY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pend <= 1'b0;
            hit_r      <= 1'b0;
            qry_x      <= '0;
            qry_y      <= '0;
        end else begin
            fetch_pend <= pend_next;
            if (state == IDLE && state_next == QFETCH) begin
                qry_x <= query_x;
                qry_y <= query_y;
            end
            if (state == QFETCH) hit_r <= map_bits[5'd31 - qry_x];
        end
    end
`endif
endmodule

// File: tb/tb_map_renderer.sv
// Directed bench for map_renderer against the standard map ROM (rows 1, 2, 5 populated).
module tb_map_renderer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  hpos, vpos;
    logic [4:0]  map_row;
    logic [31:0] map_bits;
    logic        wall_pixel;
    logic        query_valid;
    logic [4:0]  query_x, query_y;
    logic        query_ready, hit_valid, hit;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (map_row)
            5'd1:    map_bits = 32'h7FFF_FFF8;
            5'd2:    map_bits = 32'h4000_0008;
            5'd5:    map_bits = 32'h41E0_0008;
            default: map_bits = 32'h0;
        endcase
    end

    map_renderer dut (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
        .map_row(map_row), .map_bits(map_bits), .wall_pixel(wall_pixel),
        .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
        .query_ready(query_ready), .hit_valid(hit_valid), .hit(hit)
    );

    task automatic step(input int h, input int v);
        hpos = 9'(h);
        vpos = 9'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_line(input int v);
        step(256, v);
        step(257, v);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; query_valid = 1'b0; query_x = '0; query_y = '0;
        hpos = '0; vpos = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({map_row, wall_pixel, hit_valid, hit, query_ready} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {map_row, wall_pixel, hit_valid, hit, query_ready});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_line8;
        hpos = 9'd256; vpos = 9'd7; #1;
        checks++;
        if (query_ready !== 1'b0) begin failures++; $display("FAIL trig_ready got=%b exp=0", query_ready); end
        @(posedge clk); #1;
        hpos = 9'd257; #1;
        checks++;
        if (map_row !== 5'd1) begin failures++; $display("FAIL line8_map_row got=%0d exp=1", map_row); end
        @(posedge clk); #1;
        for (int h = 0; h <= 256; h++) begin
            logic e;
            step(h, 8);
            e = (h >= 8 && h < 232);
            checks++;
            if (wall_pixel !== e) begin
                failures++;
                $display("FAIL line8_px h=%0d got=%b exp=%b", h, wall_pixel, e);
            end
        end
        step(300, 8);
    endtask

`ifdef MAP_QUERY_EN
    task automatic test_query;
        int          xs[3] = '{7, 4, 28};
        int          ys[3] = '{5, 5, 2};
        logic        es[3] = '{1'b1, 1'b0, 1'b1};
        hpos = 9'd100; vpos = 9'd50;
        for (int i = 0; i < 3; i++) begin
            query_valid = 1'b1; query_x = 5'(xs[i]); query_y = 5'(ys[i]); #1;
            checks++;
            if (query_ready !== 1'b1) begin failures++; $display("FAIL q_ready_idle i=%0d got=%b exp=1", i, query_ready); end
            @(posedge clk); #1;
            query_valid = 1'b0;
            checks++;
            if ({hit_valid, query_ready, map_row} !== {2'b00, 5'(ys[i])}) begin
                failures++;
                $display("FAIL q_n1 i=%0d got=%b exp=%b", i, {hit_valid, query_ready, map_row}, {2'b00, 5'(ys[i])});
            end
            @(posedge clk); #1;
            checks++;
            if ({hit_valid, hit, query_ready} !== {1'b1, es[i], 1'b0}) begin
                failures++;
                $display("FAIL q_resp i=%0d got=%b exp=%b", i, {hit_valid, hit, query_ready}, {1'b1, es[i], 1'b0});
            end
            @(posedge clk); #1;
            checks++;
            if ({hit_valid, hit, query_ready} !== {1'b0, es[i], 1'b1}) begin
                failures++;
                $display("FAIL q_n3 i=%0d got=%b exp=%b", i, {hit_valid, hit, query_ready}, {1'b0, es[i], 1'b1});
            end
        end
    endtask
`else
    task automatic test_query;
        hpos = 9'd100; vpos = 9'd50;
        query_valid = 1'b1; query_x = 5'd7; query_y = 5'd5;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({query_ready, hit_valid, hit} !== 3'b000) begin
                failures++;
                $display("FAIL q_disabled i=%0d got=%b exp=000", i, {query_ready, hit_valid, hit});
            end
        end
        query_valid = 1'b0;
    endtask
`endif

    task automatic test_back_to_back;
        logic exp_rdy;
`ifdef MAP_QUERY_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        hpos = 9'd256; vpos = 9'd39;
        query_valid = 1'b1; query_x = 5'd7; query_y = 5'd5; #1;
        checks++;
        if (query_ready !== 1'b0) begin failures++; $display("FAIL b2b_trig_ready got=%b exp=0", query_ready); end
        @(posedge clk); #1;
        hpos = 9'd257; #1;
        checks++;
        if ({map_row, query_ready} !== {5'd5, 1'b0}) begin
            failures++;
            $display("FAIL b2b_lfetch got=%b exp=%b", {map_row, query_ready}, {5'd5, 1'b0});
        end
        @(posedge clk); #1;
        hpos = 9'd258; #1;
        checks++;
        if (query_ready !== exp_rdy) begin failures++; $display("FAIL b2b_accept got=%b exp=%b", query_ready, exp_rdy); end
        @(posedge clk); #1;
        query_valid = 1'b0;
        step(259, 39);
        checks++;
        if ({hit_valid, hit} !== {exp_rdy, exp_rdy}) begin
            failures++;
            $display("FAIL b2b_hit got=%b exp=%b", {hit_valid, hit}, {exp_rdy, exp_rdy});
        end
        step(260, 39);
        for (int h = 0; h < 256; h++) begin
            logic e;
            step(h, 40);
            e = (h >= 8 && h < 16) || (h >= 56 && h < 88) || (h >= 224 && h < 232);
            checks++;
            if (wall_pixel !== e) begin
                failures++;
                $display("FAIL line40_px h=%0d got=%b exp=%b", h, wall_pixel, e);
            end
        end
    endtask

    task automatic test_reset_midquery;
        hpos = 9'd100; vpos = 9'd40;
        query_valid = 1'b1; query_x = 5'd7; query_y = 5'd1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({map_row, wall_pixel, hit_valid, hit, query_ready} !== 9'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b exp=0", {map_row, wall_pixel, hit_valid, hit, query_ready});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(101 + i, 40);
            checks++;
            if (hit_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_hit i=%0d got=%b exp=0", i, hit_valid); end
        end
        for (int h = 0; h < 256; h++) begin
            step(h, 40);
            checks++;
            if (wall_pixel !== 1'b0) begin
                failures++;
                $display("FAIL midreset_px h=%0d got=%b exp=0", h, wall_pixel);
            end
        end
        fetch_line(40);
        step(0, 41);
        step(60, 41);
        checks++;
        if (wall_pixel !== 1'b1) begin failures++; $display("FAIL refetch_px got=%b exp=1", wall_pixel); end
    endtask

    task automatic test_vwrap;
        step(256, 261);
        hpos = 9'd257; #1;
        checks++;
        if (map_row !== 5'd0) begin failures++; $display("FAIL wrap_map_row got=%0d exp=0", map_row); end
        @(posedge clk); #1;
        for (int h = 0; h < 256; h++) begin
            step(h, 0);
            checks++;
            if (wall_pixel !== 1'b0) begin
                failures++;
                $display("FAIL line0_px h=%0d got=%b exp=0", h, wall_pixel);
            end
        end
    endtask

    initial begin
        test_reset;
        test_line8;
        test_query;
        test_back_to_back;
        test_reset_midquery;
        test_vwrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
